// File: rtl/current_source_loop_v3.sv
// Global feedback loop: times CLK windows, averages RO counts and steps a thermometer
// current-source enable up/down against a voltage window, with settle, lock detect and bypass.
module current_source_loop_v3 #(
  parameter int N_SRC      = 32,
  parameter int CNT_W      = 8,
  parameter int AVG_LOG2   = 2,
  parameter int SETTLE_CYC = 4,
  parameter int LOCK_N     = 3,
  parameter int INIT_LEVEL = 0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       LOOP_BYPASS,
  input  logic [CNT_W-1:0]           TOTAL_COUNT,
  input  logic [CNT_W-1:0]           OSC_COUNT,
  input  logic [CNT_W-1:0]           LOWER_VOLTAGE_BOUND,
  input  logic [CNT_W-1:0]           UPPER_VOLTAGE_BOUND,
  input  logic [N_SRC-1:0]           FORCE_MASK,
  output logic                       COUNT_DONE,
  output logic                       OSC_CLR,
  output logic [N_SRC-1:0]           CURRENT_SOURCE_ENABLE,
  output logic [$clog2(N_SRC+1)-1:0] LEVEL,
  output logic                       LOCKED
);

  localparam int LVL_W = $clog2(N_SRC+1);
  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int NS_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SC_W  = $clog2(SETTLE_CYC+1);
  localparam int LK_W  = $clog2(LOCK_N+1);

  typedef enum logic [1:0] {MEASURE, SAMPLE, DECIDE, SETTLE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wcnt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  avg;
  logic [NS_W-1:0]   nsamp;
  logic [SC_W-1:0]   scnt;
  logic [LK_W-1:0]   lockcnt;
  logic [LK_W-1:0]   lk_inc;
  logic [CNT_W-1:0]  win_last;
  logic              wcnt_done, samp_last, settle_done;
  logic              go_up, go_dn, step, in_band;
  logic              cd_nxt, clr_nxt;
  logic [N_SRC-1:0]  thermo;

  // A zero window length behaves as a one-cycle window.
  assign win_last    = (TOTAL_COUNT == '0) ? '0 : TOTAL_COUNT - CNT_W'(1);
  assign wcnt_done   = (wcnt == win_last);
  assign samp_last   = (nsamp == NS_W'((1 << AVG_LOG2) - 1));
  assign settle_done = (scnt == SC_W'(SETTLE_CYC - 1));

  assign avg     = acc >> AVG_LOG2;
  assign go_up   = (avg < ACC_W'(LOWER_VOLTAGE_BOUND));
  assign go_dn   = !go_up && (avg > ACC_W'(UPPER_VOLTAGE_BOUND));
  assign in_band = !go_up && !go_dn;
  assign step    = (go_up && (LEVEL != LVL_W'(N_SRC))) || (go_dn && (LEVEL != '0));
  assign lk_inc  = (lockcnt == LK_W'(LOCK_N)) ? lockcnt : lockcnt + LK_W'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= MEASURE;
      COUNT_DONE <= 1'b0;
      OSC_CLR    <= 1'b0;
    end else begin
      state      <= state_nxt;
      COUNT_DONE <= cd_nxt;
      OSC_CLR    <= clr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MEASURE: if (wcnt_done) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = samp_last ? DECIDE : MEASURE;
      DECIDE:  state_nxt = step ? SETTLE : MEASURE;
      SETTLE:  if (settle_done) state_nxt = MEASURE;
      default: state_nxt = MEASURE;
    endcase
    if (LOOP_BYPASS) state_nxt = MEASURE;
  end

  always_comb begin
    cd_nxt  = !LOOP_BYPASS && (state == MEASURE) && wcnt_done;
    clr_nxt = LOOP_BYPASS || (state == SAMPLE) || ((state == SETTLE) && settle_done);
    thermo  = '0;
    for (int i = 0; i < N_SRC; i++) thermo[i] = (LEVEL > LVL_W'(i));
    CURRENT_SOURCE_ENABLE = LOOP_BYPASS ? FORCE_MASK : thermo;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wcnt    <= '0;
      acc     <= '0;
      nsamp   <= '0;
      scnt    <= '0;
      lockcnt <= '0;
      LOCKED  <= 1'b0;
      LEVEL   <= LVL_W'(INIT_LEVEL);
    end else if (LOOP_BYPASS) begin
      wcnt    <= '0;
      acc     <= '0;
      nsamp   <= '0;
      scnt    <= '0;
      lockcnt <= '0;
      LOCKED  <= 1'b0;
    end else begin
      case (state)
        MEASURE: wcnt <= wcnt_done ? '0 : wcnt + CNT_W'(1);
        SAMPLE: begin
          acc   <= acc + ACC_W'(OSC_COUNT);
          nsamp <= nsamp + NS_W'(1);
        end
        DECIDE: begin
          acc   <= '0;
          nsamp <= '0;
          scnt  <= '0;
          if (step) begin
            LEVEL   <= go_up ? LEVEL + LVL_W'(1) : LEVEL - LVL_W'(1);
            lockcnt <= '0;
            LOCKED  <= 1'b0;
          end else if (in_band) begin
            lockcnt <= lk_inc;
            LOCKED  <= (lk_inc == LK_W'(LOCK_N));
          end else begin
            // Saturated against a rail while still out of band: never counts as locked.
            lockcnt <= '0;
            LOCKED  <= 1'b0;
          end
        end
        SETTLE: scnt <= settle_done ? '0 : scnt + SC_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_current_source_loop_v3.sv
// Scoreboard bench: stimulus queues expected decisions, monitor compares at each decision point.
module tb_current_source_loop_v3;

  logic        clk = 1'b0;
  logic        rst;
  logic        bypass;
  logic [7:0]  total, osc, lower, upper;
  logic [31:0] force_mask;
  logic        count_done, osc_clr, locked;
  logic [31:0] enable;
  logic [5:0]  level;

  typedef struct packed {
    logic [5:0] level;
    logic       locked;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  current_source_loop_v3 dut (
    .CLK                   (clk),
    .RST                   (rst),
    .LOOP_BYPASS           (bypass),
    .TOTAL_COUNT           (total),
    .OSC_COUNT             (osc),
    .LOWER_VOLTAGE_BOUND   (lower),
    .UPPER_VOLTAGE_BOUND   (upper),
    .FORCE_MASK            (force_mask),
    .COUNT_DONE            (count_done),
    .OSC_CLR               (osc_clr),
    .CURRENT_SOURCE_ENABLE (enable),
    .LEVEL                 (level),
    .LOCKED                (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_pulse(input string name);
    int n = 0;
    @(negedge clk);
    while (count_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (count_done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for COUNT_DONE actual=0 required=1", name);
    end
  endtask

  // Queue the expected decision, then feed one sample per window.
  task automatic run_decide(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                            input logic [7:0] s3, input logic [5:0] lvl, input logic lk);
    logic [7:0] s [4];
    exp_t e;
    s = '{s0, s1, s2, s3};
    e.level  = lvl;
    e.locked = lk;
    sb.push_back(e);
    for (int k = 0; k < 4; k++) begin
      osc = s[k];
      wait_pulse("window_pulse");
      @(negedge clk);
    end
  endtask

  // Monitor: window spacing, OSC_CLR after each sample, decision outcome after every 4th window.
  int   cyc = 0, last_pulse = 0, npulse = 0, pend = 0;
  bit   clr_due = 0;
  exp_t got;
  always @(negedge clk) begin
    cyc++;
    if (rst || bypass) begin
      npulse  = 0;
      pend    = 0;
      clr_due = 0;
    end else begin
      if (clr_due) begin
        chk("osc_clr_after_sample", {31'd0, osc_clr}, 32'd1);
        clr_due = 0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_decision actual=level %0d required=none", level);
          end else begin
            got = sb.pop_front();
            chk("decide_level", {26'd0, level}, {26'd0, got.level});
            chk("decide_locked", {31'd0, locked}, {31'd0, got.locked});
          end
        end
      end
      if (count_done === 1'b1) begin
        clr_due = 1;
        if (npulse != 0)
          chk("window_period", cyc - last_pulse, ((total == 8'd0) ? 1 : int'(total)) + 1);
        last_pulse = cyc;
        npulse++;
        if (npulse == 4) begin
          npulse = 0;
          pend   = 2;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; bypass = 1'b0; total = 8'd10; osc = 8'd20;
    lower = 8'd50; upper = 8'd60; force_mask = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // First decision, then an asynchronous reset mid-settle must clear everything at once.
    run_decide(20, 20, 20, 20, 1, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("reset_enable", enable, 32'd0);
    chk("reset_level", {26'd0, level}, 32'd0);
    chk("reset_locked", {31'd0, locked}, 32'd0);
    chk("reset_count_done", {31'd0, count_done}, 32'd0);
    chk("reset_osc_clr", {31'd0, osc_clr}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Step up all the way to the rail, then a saturated hold.
    for (int i = 1; i <= 32; i++) run_decide(20, 20, 20, 20, 6'(i), 0);
    @(negedge clk);
    chk("full_enable", enable, 32'hFFFF_FFFF);
    chk("full_level", {26'd0, level}, 32'd32);
    run_decide(20, 20, 20, 20, 32, 0);

    // Lock after three in-band decisions, then step down.
    run_decide(55, 55, 55, 55, 32, 0);
    run_decide(55, 55, 55, 55, 32, 0);
    run_decide(55, 55, 55, 55, 32, 1);
    run_decide(70, 70, 70, 70, 31, 0);

    // Averaging and band edges (avg truncates: 224/4=56, 201/4=50, 243/4=60, 197/4=49).
    run_decide(40, 60, 60, 64, 31, 0);
    run_decide(60, 60, 60, 60, 31, 0);
    run_decide(50, 50, 50, 51, 31, 1);
    run_decide(61, 61, 61, 60, 31, 1);
    run_decide(49, 49, 49, 50, 32, 0);

    // Zero window length behaves as one cycle.
    total = 8'd0;
    run_decide(70, 70, 70, 70, 31, 0);
    total = 8'd10;

    // Bypass mid-window.
    osc = 8'd55;
    wait_pulse("bypass_pre_pulse");
    repeat (3) @(negedge clk);
    force_mask = 32'h0000_00F0;
    bypass = 1'b1;
    #1;
    chk("bypass_enable_comb", enable, 32'h0000_00F0);
    repeat (3) @(negedge clk);
    chk("bypass_level_frozen", {26'd0, level}, 32'd31);
    chk("bypass_locked", {31'd0, locked}, 32'd0);
    chk("bypass_osc_clr", {31'd0, osc_clr}, 32'd1);
    chk("bypass_count_done", {31'd0, count_done}, 32'd0);
    chk("bypass_enable_hold", enable, 32'h0000_00F0);
    bypass = 1'b0;
    #1;
    chk("release_enable", enable, 32'h7FFF_FFFF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (count_done !== 1'b1 && n < 50);
    chk("release_window_len", n, 32'd10);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
